// File: rtl/ttc3_fuse_reader.sv
// Sequences word reads from the eFuse/OTP macro after reset and assembles the device ID.
// Optional parity word check (XOR of all ID words) is enabled with `define FUSE_ECC_EN.
module ttc3_fuse_reader #(
  parameter int ID_WIDTH       = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  fuse_rd_req,
  output logic [ADDR_WIDTH-1:0] fuse_addr,
  input  logic [WORD_WIDTH-1:0] fuse_rd_data,
  input  logic                  fuse_rd_ack,
  output logic                  fuse_valid,
  output logic [ID_WIDTH-1:0]   fuse_id,
  output logic                  read_done,
  output logic                  read_error,
  output logic                  fuse_blank
);

  localparam int NUM_WORDS = ID_WIDTH / WORD_WIDTH;
`ifdef FUSE_ECC_EN
  localparam int NUM_READS = NUM_WORDS + 1;
`else
  localparam int NUM_READS = NUM_WORDS;
`endif
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST  = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_READS - 1);

  localparam logic [2:0] SETTLE = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] GAP    = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERROR  = 3'd5;

  logic [2:0]            state_reg;
  logic [SW-1:0]         settle_cnt_reg;
  logic [TW-1:0]         timeout_cnt_reg;
  logic [ADDR_WIDTH-1:0] idx_reg;
  logic [WORD_WIDTH-1:0] word_reg [NUM_WORDS];
  logic [ID_WIDTH-1:0]   fuse_id_int;
  logic                  id_blank;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_assemble
      assign fuse_id_int[gi*WORD_WIDTH +: WORD_WIDTH] = word_reg[gi];
    end
  endgenerate

  assign id_blank    = (fuse_id_int == '0);
  // Request is decoded from state so an asynchronous reset drops it at once.
  assign fuse_rd_req = (state_reg == REQ);
  assign fuse_addr   = idx_reg;

`ifdef FUSE_ECC_EN
  logic [WORD_WIDTH-1:0] parity_reg;
  logic [WORD_WIDTH-1:0] word_xor;

  always_comb begin
    word_xor = '0;
    for (int i = 0; i < NUM_WORDS; i++) word_xor = word_xor ^ word_reg[i];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_reg <= '0;
    end else if (state_reg == REQ && fuse_rd_ack && idx_reg == ADDR_WIDTH'(NUM_WORDS)) begin
      parity_reg <= fuse_rd_data;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= SETTLE;
      settle_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      idx_reg         <= '0;
      for (int i = 0; i < NUM_WORDS; i++) word_reg[i] <= '0;
      fuse_valid      <= 1'b0;
      fuse_id         <= '0;
      read_done       <= 1'b0;
      read_error      <= 1'b0;
      fuse_blank      <= 1'b0;
    end else begin
      case (state_reg)
        SETTLE: begin
          if (SETTLE_CYCLES == 0 || settle_cnt_reg == SETTLE_LAST) begin
            state_reg <= REQ;
            idx_reg   <= '0;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        REQ: begin
          // An ack arriving on the final allowed cycle still counts as success.
          if (fuse_rd_ack) begin
            for (int i = 0; i < NUM_WORDS; i++)
              if (idx_reg == ADDR_WIDTH'(i)) word_reg[i] <= fuse_rd_data;
            state_reg <= GAP;
          end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
            state_reg  <= ERROR;
            read_error <= 1'b1;
            read_done  <= 1'b1;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
        end
        GAP: begin
          timeout_cnt_reg <= '0;
          if (idx_reg == LAST_IDX) begin
            state_reg <= CHECK;
          end else begin
            idx_reg   <= idx_reg + 1'b1;
            state_reg <= REQ;
          end
        end
        CHECK: begin
          read_done <= 1'b1;
`ifdef FUSE_ECC_EN
          if (id_blank && parity_reg == '0) begin
            fuse_blank <= 1'b1;
            state_reg  <= DONE;
          end else if (parity_reg != word_xor) begin
            read_error <= 1'b1;
            state_reg  <= ERROR;
          end else begin
            fuse_valid <= 1'b1;
            fuse_id    <= fuse_id_int;
            state_reg  <= DONE;
          end
`else
          if (id_blank) begin
            fuse_blank <= 1'b1;
          end else begin
            fuse_valid <= 1'b1;
            fuse_id    <= fuse_id_int;
          end
          state_reg <= DONE;
`endif
        end
        default: state_reg <= state_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_ttc3_fuse_reader.sv
// Scoreboard bench for ttc3_fuse_reader: a fuse macro responder with per-word ack latency,
// a timeline reference model pushing expected results, and a monitor checking each finished read.
module tb_ttc3_fuse_reader;

  localparam int NW = 4;
`ifdef FUSE_ECC_EN
  localparam int NR = NW + 1;
`else
  localparam int NR = NW;
`endif
  localparam int NEVER = 1000;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         fuse_rd_req;
  logic [3:0]   fuse_addr;
  logic [31:0]  fuse_rd_data;
  logic         fuse_rd_ack;
  logic         fuse_valid;
  logic [127:0] fuse_id;
  logic         read_done;
  logic         read_error;
  logic         fuse_blank;

  ttc3_fuse_reader dut (
    .clock(clock), .reset_n(reset_n), .fuse_rd_req(fuse_rd_req), .fuse_addr(fuse_addr),
    .fuse_rd_data(fuse_rd_data), .fuse_rd_ack(fuse_rd_ack), .fuse_valid(fuse_valid),
    .fuse_id(fuse_id), .read_done(read_done), .read_error(read_error), .fuse_blank(fuse_blank)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         valid;
    logic [127:0] id;
    logic         blank;
    logic         err;
    int           done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [16];
  int          lat [16];
  bit          spurious_en = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: walk the per-word timeline (each word costs latency+1 request cycles plus one gap).
  function automatic exp_t model();
    exp_t e;
    int t;
    logic [127:0] id;
    logic [31:0] x;
    e.valid = 0; e.id = '0; e.blank = 0; e.err = 0;
    t = 16;
    for (int k = 0; k < NR; k++) begin
      if (lat[k] >= 64) begin
        e.err = 1; e.done_cyc = t + 64;
        return e;
      end
      t += lat[k] + 2;
    end
    e.done_cyc = t + 1;
    id = {mem[3], mem[2], mem[1], mem[0]};
    x = mem[0] ^ mem[1] ^ mem[2] ^ mem[3];
`ifdef FUSE_ECC_EN
    if (id == '0 && mem[4] == '0) e.blank = 1;
    else if (mem[4] != x) e.err = 1;
    else begin e.valid = 1; e.id = id; end
`else
    if (x === 'x) e.err = 1;
    if (id == '0) e.blank = 1;
    else begin e.valid = 1; e.id = id; end
`endif
    return e;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc = reset_n ? cyc + 1 : 0;
  end

  // Fuse macro responder: acks each request after its programmed latency, optional spurious acks.
  initial begin
    int req_cnt, words_seen, gap_len;
    logic [3:0] cur_addr;
    req_cnt = 0; words_seen = 0; gap_len = 0; cur_addr = '0;
    fuse_rd_ack = 0; fuse_rd_data = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        req_cnt = 0; words_seen = 0; gap_len = 0; fuse_rd_ack = 0;
      end else if (fuse_rd_req) begin
        if (req_cnt == 0) begin
          chk("req_addr_order", 128'(fuse_addr), 128'(words_seen));
          if (words_seen > 0) chk("gap_len", 128'(gap_len), 128'd1);
          cur_addr = fuse_addr;
          words_seen++;
        end else begin
          chk("addr_stable", 128'(fuse_addr), 128'(cur_addr));
        end
        if (req_cnt == lat[cur_addr]) begin
          fuse_rd_ack = 1; fuse_rd_data = mem[cur_addr];
        end else begin
          fuse_rd_ack = 0; fuse_rd_data = $urandom;
        end
        req_cnt++; gap_len = 0;
      end else begin
        req_cnt = 0; gap_len++;
        if (spurious_en && $urandom_range(0, 1) == 1) begin
          fuse_rd_ack = 1; fuse_rd_data = 32'hFFFF_FFFF;
        end else begin
          fuse_rd_ack = 0;
        end
      end
    end
  end

  // Monitor: on each rising read_done, pop the expected result and compare.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 0;
    forever begin
      @(negedge clock);
      if (reset_n && read_done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("fuse_valid", 128'(fuse_valid), 128'(e.valid));
          chk("fuse_id", fuse_id, e.id);
          chk("fuse_blank", 128'(fuse_blank), 128'(e.blank));
          chk("read_error", 128'(read_error), 128'(e.err));
          chk("done_cycle", 128'(cyc), 128'(e.done_cyc));
        end
      end
      done_prev = reset_n ? read_done : 1'b0;
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req"}, 128'(fuse_rd_req), 128'd0);
    chk({tag, "_outs"}, {fuse_valid, read_done, read_error, fuse_blank, fuse_addr}, 128'd0);
    chk({tag, "_id"}, fuse_id, 128'd0);
  endtask

  task automatic run_seq(input bit abort);
    int n;
    reset_n = 0;
    @(negedge clock);
    @(negedge clock);
    check_zero_outputs("reset");
    reset_n = 1;
    if (!abort) begin
      exp_q.push_back(model());
      n = 0;
      while (!read_done && n < 3000) begin @(negedge clock); n++; end
      if (!read_done) chk("done_timeout", 128'd1, 128'd0);
      @(negedge clock);
      n = 0;
      for (int i = 0; i < 100; i++) begin @(negedge clock); if (fuse_rd_req) n++; end
      chk("post_done_req", 128'(n), 128'd0);
    end else begin
      n = 0;
      while (!(fuse_rd_req && fuse_addr == 4'd2) && n < 500) begin @(negedge clock); n++; end
      if (n >= 500) chk("abort_wait", 128'd1, 128'd0);
      #2 reset_n = 0;
      #1 check_zero_outputs("async_reset");
    end
  endtask

  task automatic set_base();
    for (int k = 0; k < 16; k++) begin mem[k] = $urandom; lat[k] = 0; end
    mem[0] = 32'h89AB_CDEF; mem[1] = 32'h0123_4567;
    mem[2] = 32'hCAFE_BABE; mem[3] = 32'hDEAD_BEEF;
    mem[4] = mem[0] ^ mem[1] ^ mem[2] ^ mem[3];
  endtask

  initial begin
    set_base();
    run_seq(0);
    set_base(); lat[2] = 5;
    run_seq(0);
    set_base(); lat[0] = 63;
    run_seq(0);
    set_base(); lat[3] = 64;
    run_seq(0);
    set_base(); for (int k = 0; k < NR; k++) mem[k] = '0;
    run_seq(0);
    set_base(); lat[1] = NEVER;
    run_seq(0);
    set_base(); spurious_en = 1;
    run_seq(0);
    run_seq(1);
    run_seq(0);
    spurious_en = 0;
`ifdef FUSE_ECC_EN
    set_base(); mem[4] = mem[4] ^ 32'h1;
    run_seq(0);
`endif
    for (int r = 0; r < 12; r++) begin
      set_base();
      for (int k = 0; k < NR; k++) begin mem[k] = $urandom; lat[k] = $urandom_range(0, 4); end
      if ($urandom_range(0, 4) == 0) for (int k = 0; k < NW; k++) mem[k] = '0;
      mem[4] = mem[0] ^ mem[1] ^ mem[2] ^ mem[3];
      if ($urandom_range(0, 3) == 0) mem[4] = mem[4] ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) lat[$urandom_range(0, NR - 1)] = ($urandom_range(0, 1) == 1) ? 63 : NEVER;
      spurious_en = ($urandom_range(0, 1) == 1);
      run_seq(0);
    end
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ttc3_fuse_reader.md
Name: ttc3_fuse_reader

Overview:
- Upstream feeder for the TTC3 device ID store.
- After reset, sequences word-by-word reads from the eFuse/OTP macro and assembles the ID_WIDTH-bit identity.
- Presents the result on fuse_valid/fuse_id to the device ID block.
- Detects blank (unprogrammed) fuses and read timeouts; on either, fuse_valid stays low so the default ID is used.

Parameters:
- ID_WIDTH, 128: width of assembled ID; must be a multiple of WORD_WIDTH.
- WORD_WIDTH, 32: fuse macro read data width.
- ADDR_WIDTH, 4: fuse word address width; must satisfy 2**ADDR_WIDTH > ID_WIDTH/WORD_WIDTH.
- SETTLE_CYCLES, 16: cycles to wait after reset release before the first read (fuse sense-amp settle).
- TIMEOUT_CYCLES, 64: maximum cycles fuse_rd_req may stay high without fuse_rd_ack.
- NUM_WORDS (localparam): ID_WIDTH/WORD_WIDTH.

Ports:
- clock, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- fuse_rd_req, output, 1: read request to fuse macro.
- fuse_addr, output, ADDR_WIDTH: word address; stable while fuse_rd_req is high.
- fuse_rd_data, input, WORD_WIDTH: read data; valid in the cycle fuse_rd_ack is high.
- fuse_rd_ack, input, 1: read acknowledge, one-cycle pulse or level.
- fuse_valid, output, 1: assembled ID valid and non-blank; sticky until reset.
- fuse_id, output, ID_WIDTH: assembled ID; all-zero whenever fuse_valid is 0.
- read_done, output, 1: sequence finished (success, blank or error); sticky.
- read_error, output, 1: timeout (or parity mismatch with FUSE_ECC_EN); sticky.
- fuse_blank, output, 1: all words read as zero; sticky.

Behaviour:
- Reset (reset_n low, asynchronous): state SETTLE, counters 0, shift register 0.
- All outputs 0 during reset; fuse_rd_req drops immediately, even mid-transaction.
- FSM states: SETTLE, REQ, GAP, CHECK, DONE, ERROR.
- SETTLE:
  - Counts SETTLE_CYCLES clocks after reset release, then goes to REQ with word index 0.
  - SETTLE_CYCLES=0 means REQ on the first clock.
- REQ:
  - fuse_rd_req=1, fuse_addr=word index.
  - On a clock where fuse_rd_ack=1: capture fuse_rd_data into fuse_id_int[idx*WORD_WIDTH +: WORD_WIDTH] (word 0 = LSBs), go to GAP.
  - The timeout counter increments each REQ cycle without ack. Reaching TIMEOUT_CYCLES -> ERROR.
  - An ack in the same cycle the counter reaches its limit counts as success (ack wins).
- GAP:
  - fuse_rd_req=0 for exactly one cycle; timeout counter cleared.
  - If idx==last word -> CHECK, else idx+1 -> REQ.
  - fuse_addr holds the last value.
- fuse_rd_ack while fuse_rd_req=0 (SETTLE/GAP/CHECK/DONE/ERROR) is ignored; no capture.
- Minimum per-word cost is 2 cycles (REQ with immediate ack + GAP).
- With immediate ack, read_done rises SETTLE_CYCLES + 2*NUM_WORDS + 1 clocks after the first post-reset edge.
- CHECK (one cycle):
  - If assembled ID == 0: fuse_blank=1, fuse_valid=0.
  - Otherwise fuse_valid=1 and fuse_id=assembled value.
  - Go to DONE.
- DONE: read_done=1; terminal until reset; no further requests.
- ERROR: read_error=1, read_done=1, fuse_valid=0, fuse_id=0; terminal until reset.
- fuse_id is registered; fuse_valid and fuse_id change in the same cycle.

Optional Feature:
- Macro: FUSE_ECC_EN.
- Defined:
  - After the last ID word, one extra word is read at address NUM_WORDS through the same REQ/GAP handshake.
  - That word must equal the XOR of all ID words.
  - All ID words zero AND parity word zero -> blank (no error).
  - Any other mismatch -> ERROR with read_error=1, fuse_valid=0.
  - Latency gains 2 cycles with immediate ack.
- Undefined: only NUM_WORDS reads are issued; no parity check; address NUM_WORDS is never driven.

Test Plan:
- Defaults, immediate ack, words 0..3 = 89ABCDEF, 01234567, CAFEBABE, DEADBEEF -> fuse_id = DEADBEEF_CAFEBABE_01234567_89ABCDEF, fuse_valid=1, read_done at cycle 25, read_error=0.
- Ack delayed 5 cycles on word 2 -> fuse_rd_req stays high 6 cycles with fuse_addr=2 stable; final ID correct; fuse_rd_req low exactly 1 cycle between words.
- All words read 0 -> fuse_blank=1, fuse_valid=0, fuse_id=0, read_done=1, read_error=0.
- Never ack word 1 -> after 64 REQ cycles read_error=1, read_done=1, fuse_valid=0, no further requests for 100 cycles.
- Spurious ack pulses during SETTLE and GAP with data FFFFFFFF -> ignored; ID matches the first scenario. Then assert reset_n low mid-REQ on word 2 -> all outputs 0 immediately; the sequence restarts from word 0 after release.
- FUSE_ECC_EN: parity word = XOR of the first-scenario words -> fuse_valid=1. Same words with parity bit 0 flipped -> read_error=1, fuse_valid=0.
